dev_gpo_ctl: RTL and testbench



---
 rtl/dev_gpo_ctl_if.sv | 27 ++
 rtl/dev_gpo_ctl.sv | 115 +++++++++++
 tb/tb_dev_gpo_ctl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dev_gpo_ctl_if.sv
// WISHBONE slave-side bus bundle for the GPO controller MMIO slot.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface dev_gpo_ctl_if;
  logic [`REG_ADDR_WIDTH-1:0] ADDR_I;
  logic [`DATA_WIDTH-1:0]     DAT_I;
  logic [`DATA_WIDTH-1:0]     DAT_O;
  logic                       CYC_I;
  logic                       STB_I;
  logic                       WE_I;
  logic                       ACK_O;

  modport master (
    output ADDR_I, DAT_I, CYC_I, STB_I, WE_I,
    input  DAT_O, ACK_O
  );

  modport slave (
    input  ADDR_I, DAT_I, CYC_I, STB_I, WE_I,
    output DAT_O, ACK_O
  );
endinterface

// File: rtl/dev_gpo_ctl.sv
// General-purpose output controller: atomic set/clear/toggle, readback and
// per-bit one-shot pulses that invert the static output level for plen cycles.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module dev_gpo_ctl #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic         CLK_I,
  input  logic         RST_N_I,
  dev_gpo_ctl_if.slave bus,
  output logic [W-1:0] dout
);
  localparam int unsigned DW = `DATA_WIDTH;

  typedef enum logic [2:0] {
    AddrData   = 3'd0,
    AddrSet    = 3'd1,
    AddrClr    = 3'd2,
    AddrTgl    = 3'd3,
    AddrPlen   = 3'd4,
    AddrPulse  = 3'd5,
    AddrStatus = 3'd6,
    AddrRsvd   = 3'd7
  } reg_addr_e;

  logic [W-1:0]            out_buf_q, out_buf_d;
  logic [CNT_W-1:0]        plen_q, plen_d;
  logic [W-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                    ack_q;
  logic [DW-1:0]           dat_q, dat_d, rdata;
  logic [W-1:0]            active, wmask;
  logic                    acc, wr, rd, pulse_wr;
  reg_addr_e               addr;
  logic                    unused_bus;

  assign addr     = reg_addr_e'(bus.ADDR_I[2:0]);
  assign acc      = bus.CYC_I & bus.STB_I & ~ack_q;
  assign wr       = acc & bus.WE_I;
  assign rd       = acc & ~bus.WE_I;
  assign wmask    = bus.DAT_I[W-1:0];
  // A zero pulse length leaves running counters untouched rather than cancelling them.
  assign pulse_wr = wr && (addr == AddrPulse) && (plen_q != '0);

  always_comb begin
    for (int i = 0; i < W; i++) begin
      active[i] = (cnt_q[i] != '0);
    end
  end

  assign dout = out_buf_q ^ active;

  always_comb begin
    out_buf_d = out_buf_q;
    plen_d    = plen_q;
    if (wr) begin
      case (addr)
        AddrData: out_buf_d = wmask;
        AddrSet:  out_buf_d = out_buf_q | wmask;
        AddrClr:  out_buf_d = out_buf_q & ~wmask;
        AddrTgl:  out_buf_d = out_buf_q ^ wmask;
        AddrPlen: plen_d    = bus.DAT_I[CNT_W-1:0];
        default:  ;
      endcase
    end
  end

  // Reload takes priority over the decrement, so a retrigger never shows a gap.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      cnt_d[i] = active[i] ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
      if (pulse_wr && wmask[i]) begin
        cnt_d[i] = plen_q;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      AddrData:                 rdata[W-1:0]     = dout;
      AddrSet, AddrClr, AddrTgl: rdata[W-1:0]    = out_buf_q;
      AddrPlen:                 rdata[CNT_W-1:0] = plen_q;
      AddrPulse, AddrStatus:    rdata[W-1:0]     = active;
      default:                  ;
    endcase
    dat_d = rd ? rdata : dat_q;
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      out_buf_q <= '0;
      plen_q    <= CNT_W'(1);
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      out_buf_q <= out_buf_d;
      plen_q    <= plen_d;
      cnt_q     <= cnt_d;
      ack_q     <= acc;
      dat_q     <= dat_d;
    end
  end

  assign bus.ACK_O = ack_q;
  assign bus.DAT_O = dat_q;

  assign unused_bus = ^{bus.ADDR_I, bus.DAT_I};
endmodule

// File: tb/tb_dev_gpo_ctl.sv
// Self-checking bench for dev_gpo_ctl: constant vector table, directed pulse
// sequences and randomized traffic against a cycle-stamp reference model.
module tb_dev_gpo_ctl;
  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 16;

  logic         CLK_I = 1'b0;
  logic         RST_N_I = 1'b0;
  logic [W-1:0] dout;

  dev_gpo_ctl_if bus_if ();

  dev_gpo_ctl #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_dut (
    .CLK_I   (CLK_I),
    .RST_N_I (RST_N_I),
    .bus     (bus_if),
    .dout    (dout)
  );

  always #5 CLK_I = ~CLK_I;

  int total = 0;
  int bad   = 0;

  // Reference model: pulses are tracked as the absolute cycle at which they end.
  longint           cyc = 0;
  logic [W-1:0]     mbuf = '0;
  logic [CNT_W-1:0] mplen = 16'd1;
  longint           pend [W];
  logic [W-1:0]     trace [$];

  always @(posedge CLK_I) cyc <= cyc + 1;

  always @(posedge CLK_I) begin
    #1;
    trace.push_back(dout);
  end

  function automatic logic [W-1:0] m_active();
    logic [W-1:0] r = '0;
    for (int i = 0; i < W; i++) r[i] = (cyc < pend[i]);
    return r;
  endfunction

  function automatic logic [W-1:0] m_dout();
    return mbuf ^ m_active();
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:          return 32'(m_dout());
      3'd1, 3'd2, 3'd3: return 32'(mbuf);
      3'd4:          return 32'(mplen);
      3'd5, 3'd6:    return 32'(m_active());
      default:       return 32'd0;
    endcase
  endfunction

  task automatic m_write(input logic [2:0] a, input logic [31:0] d);
    case (a)
      3'd0: mbuf = d[W-1:0];
      3'd1: mbuf = mbuf | d[W-1:0];
      3'd2: mbuf = mbuf & ~d[W-1:0];
      3'd3: mbuf = mbuf ^ d[W-1:0];
      3'd4: mplen = d[CNT_W-1:0];
      3'd5: if (mplen != 0) begin
        for (int i = 0; i < W; i++) if (d[i]) pend[i] = cyc + longint'(mplen);
      end
      default: ;
    endcase
  endtask

  task automatic m_reset();
    mbuf  = '0;
    mplen = 16'd1;
    for (int i = 0; i < W; i++) pend[i] = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge CLK_I);
      #1;
      chk("idle_dout", 32'(dout), 32'(m_dout()));
    end
  endtask

  // One single-beat transfer; ack must appear on the first edge, then one idle edge.
  task automatic xfer(input logic we, input logic [2:0] a, input logic [31:0] d,
                      output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic [31:0] araw;
    @(negedge CLK_I);
    exp_rd = m_read(a);
    araw = $urandom;
    araw[2:0] = a;
    bus_if.ADDR_I = araw[`REG_ADDR_WIDTH-1:0];
    bus_if.DAT_I  = d;
    bus_if.WE_I   = we;
    bus_if.CYC_I  = 1'b1;
    bus_if.STB_I  = 1'b1;
    @(posedge CLK_I);
    #1;
    chk("ack_rise", 32'(bus_if.ACK_O), 32'd1);
    if (we) m_write(a, d);
    else chk("read_data", bus_if.DAT_O, exp_rd);
    rd = bus_if.DAT_O;
    chk("dout_at_ack", 32'(dout), 32'(m_dout()));
    bus_if.CYC_I = 1'b0;
    bus_if.STB_I = 1'b0;
    bus_if.WE_I  = 1'b0;
    @(posedge CLK_I);
    #1;
    chk("ack_fall", 32'(bus_if.ACK_O), 32'd0);
    chk("dout_after", 32'(dout), 32'(m_dout()));
  endtask

  function automatic int run_len(input int start, input int b, input logic lvl);
    int i = start;
    int n = 0;
    while (i < trace.size() && trace[i][b] !== lvl) i++;
    while (i < trace.size() && trace[i][b] === lvl) begin
      n++;
      i++;
    end
    return n;
  endfunction

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;   // dout after a write, read data for a read
  } vec_t;

  initial begin
    vec_t        tbl [$];
    logic [31:0] rd;
    int          ts;
    int          toggles;
    logic        prev;

    m_reset();
    bus_if.ADDR_I = '0;
    bus_if.DAT_I  = '0;
    bus_if.CYC_I  = 1'b0;
    bus_if.STB_I  = 1'b0;
    bus_if.WE_I   = 1'b0;
    repeat (3) @(negedge CLK_I);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_ack", 32'(bus_if.ACK_O), 32'd0);
    RST_N_I = 1'b1;

    tbl.push_back('{1'b0, 3'd4, 32'h0,        32'h1});
    tbl.push_back('{1'b0, 3'd6, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 3'd0, 32'h0F,       32'h0F});
    tbl.push_back('{1'b1, 3'd1, 32'h30,       32'h3F});
    tbl.push_back('{1'b1, 3'd2, 32'h03,       32'h3C});
    tbl.push_back('{1'b1, 3'd3, 32'h81,       32'hBD});
    tbl.push_back('{1'b0, 3'd0, 32'h0,        32'hBD});
    tbl.push_back('{1'b0, 3'd3, 32'h0,        32'hBD});
    tbl.push_back('{1'b1, 3'd6, 32'hFF,       32'hBD});
    tbl.push_back('{1'b1, 3'd7, 32'hFF,       32'hBD});
    tbl.push_back('{1'b0, 3'd7, 32'h0,        32'h0});
    tbl.push_back('{1'b0, 3'd4, 32'h0,        32'h1});
    tbl.push_back('{1'b1, 3'd4, 32'h0,        32'hBD});
    tbl.push_back('{1'b1, 3'd5, 32'hFF,       32'hBD});
    tbl.push_back('{1'b0, 3'd6, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 3'd4, 32'h3,        32'hBD});
    tbl.push_back('{1'b1, 3'd5, 32'hFFFFFF00, 32'hBD});
    tbl.push_back('{1'b0, 3'd6, 32'h0,        32'h0});
    tbl.push_back('{1'b0, 3'd4, 32'h0,        32'h3});
    foreach (tbl[k]) begin
      xfer(tbl[k].we, tbl[k].addr, tbl[k].data, rd);
      if (tbl[k].we) chk("tbl_dout", 32'(dout), tbl[k].exp);
      else chk("tbl_read", rd, tbl[k].exp);
    end

    // Pulse width with static level low, then high.
    xfer(1'b1, 3'd0, 32'h00, rd);
    xfer(1'b1, 3'd4, 32'd5, rd);
    ts = trace.size();
    xfer(1'b1, 3'd5, 32'h04, rd);
    xfer(1'b0, 3'd6, 32'h0, rd);
    chk("status_during", rd, 32'h04);
    idle(8);
    chk("width_high", 32'(run_len(ts, 2, 1'b1)), 32'd5);
    xfer(1'b0, 3'd6, 32'h0, rd);
    chk("status_after", rd, 32'h00);
    xfer(1'b1, 3'd0, 32'h04, rd);
    ts = trace.size();
    xfer(1'b1, 3'd5, 32'h04, rd);
    idle(8);
    chk("width_low", 32'(run_len(ts, 2, 1'b0)), 32'd5);

    // Retrigger at cycle 6 extends the pulse to 16 cycles with no gap.
    xfer(1'b1, 3'd0, 32'h00, rd);
    xfer(1'b1, 3'd4, 32'd10, rd);
    ts = trace.size();
    xfer(1'b1, 3'd5, 32'h01, rd);
    idle(4);
    xfer(1'b1, 3'd5, 32'h01, rd);
    idle(20);
    chk("retrigger_len", 32'(run_len(ts, 0, 1'b1)), 32'd16);

    // Static write under a running pulse.
    xfer(1'b1, 3'd5, 32'h01, rd);
    xfer(1'b1, 3'd1, 32'h01, rd);
    chk("set_in_pulse", 32'(dout[0]), 32'd0);
    idle(10);
    chk("set_after_pulse", 32'(dout[0]), 32'd1);

    // Held strobe: ack on alternate cycles, one toggle per ack.
    xfer(1'b1, 3'd0, 32'h00, rd);
    @(negedge CLK_I);
    bus_if.ADDR_I = `REG_ADDR_WIDTH'(3);
    bus_if.DAT_I  = 32'h01;
    bus_if.WE_I   = 1'b1;
    bus_if.CYC_I  = 1'b1;
    bus_if.STB_I  = 1'b1;
    toggles = 0;
    prev = dout[0];
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK_I);
      #1;
      chk("held_ack", 32'(bus_if.ACK_O), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) m_write(3'd3, 32'h01);
      chk("held_dout", 32'(dout), 32'(m_dout()));
      if (dout[0] !== prev) toggles++;
      prev = dout[0];
    end
    bus_if.CYC_I = 1'b0;
    bus_if.STB_I = 1'b0;
    bus_if.WE_I  = 1'b0;
    chk("held_toggles", 32'(toggles), 32'd2);
    idle(2);

    // Asynchronous reset mid-pulse and mid-transfer.
    xfer(1'b1, 3'd0, 32'h5A, rd);
    xfer(1'b1, 3'd4, 32'd10, rd);
    xfer(1'b1, 3'd5, 32'h0F, rd);
    @(negedge CLK_I);
    bus_if.ADDR_I = '0;
    bus_if.WE_I   = 1'b0;
    bus_if.CYC_I  = 1'b1;
    bus_if.STB_I  = 1'b1;
    @(posedge CLK_I);
    #1;
    chk("pre_rst_ack", 32'(bus_if.ACK_O), 32'd1);
    #2;
    RST_N_I = 1'b0;
    #1;
    chk("async_rst_dout", 32'(dout), 32'd0);
    chk("async_rst_ack", 32'(bus_if.ACK_O), 32'd0);
    chk("async_rst_dat", bus_if.DAT_O, 32'd0);
    bus_if.CYC_I = 1'b0;
    bus_if.STB_I = 1'b0;
    m_reset();
    @(negedge CLK_I);
    RST_N_I = 1'b1;
    xfer(1'b0, 3'd4, 32'h0, rd);
    chk("post_rst_plen", rd, 32'h1);
    xfer(1'b0, 3'd6, 32'h0, rd);
    chk("post_rst_status", rd, 32'h0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic        we;
      logic [2:0]  a;
      logic [31:0] d;
      we = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      d  = $urandom;
      if (a == 3'd4) d = $urandom_range(0, 12);
      xfer(we, a, d, rd);
      idle(int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
